// File: rtl/conv3x3_stream.sv
// Streaming 3x3 Sobel engine: two line buffers feed a 3x3 window, then a kernel stage and an output register.
// Optional build macro CONV_THRESH_EN adds a per-frame threshold that binarises the gradient modes.
module conv3x3_stream #(
    parameter int DATA_W  = 12,
    parameter int IMG_W   = 1280,
    parameter int IMG_H   = 960,
    parameter int COORD_W = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  data_in,
    input  logic               read,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
`ifdef CONV_THRESH_EN
    input  logic [DATA_W-1:0]  thresh,
`endif
    input  logic [1:0]         mode,
    output logic [DATA_W-1:0]  data_out,
    output logic               valid,
    output logic               frame_done,
    output logic               seq_err
);

    localparam int GW = DATA_W + 4;
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [GW:0] SAT_MAX = {{5{1'b0}}, {DATA_W{1'b1}}};
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 1);
    localparam logic [COORD_W-1:0] TWO    = COORD_W'(2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [COORD_W-1:0] exp_x_q, exp_x_d;
    logic [COORD_W-1:0] exp_y_q, exp_y_d;
    logic [1:0]         mode_q;
    logic               seq_err_q;
`ifdef CONV_THRESH_EN
    logic [DATA_W-1:0]  thresh_q;
`endif

    logic accept, start, err;
    logic at_origin, at_exp, is_last;

    assign at_origin = (x == '0) && (y == '0);
    assign at_exp    = (x == exp_x_q) && (y == exp_y_q);
    assign is_last   = (x == X_LAST) && (y == Y_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    logic s2_last_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN: begin
                if (err) begin
                    state_d = S_IDLE;
                end else if (accept && is_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: if (s2_last_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        accept = 1'b0;
        start  = 1'b0;
        err    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (read && at_origin) begin
                    accept = 1'b1;
                    start  = 1'b1;
                end
            end
            S_RUN: begin
                if (read) begin
                    if (at_origin) begin
                        accept = 1'b1;
                        start  = 1'b1;
                    end else if (at_exp) begin
                        accept = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Expected coordinate follows the accepted pixel; an error rewinds it.
    always_comb begin
        exp_x_d = exp_x_q;
        exp_y_d = exp_y_q;
        if (err) begin
            exp_x_d = '0;
            exp_y_d = '0;
        end else if (accept) begin
            if (x == X_LAST) begin
                exp_x_d = '0;
                exp_y_d = y + COORD_W'(1);
            end else begin
                exp_x_d = x + COORD_W'(1);
                exp_y_d = y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_x_q   <= '0;
            exp_y_q   <= '0;
            mode_q    <= 2'b00;
            seq_err_q <= 1'b0;
`ifdef CONV_THRESH_EN
            thresh_q  <= '0;
`endif
        end else begin
            exp_x_q   <= exp_x_d;
            exp_y_q   <= exp_y_d;
            seq_err_q <= seq_err_q | err;
            if (start) begin
                mode_q   <= mode;
`ifdef CONV_THRESH_EN
                thresh_q <= thresh;
`endif
            end
        end
    end

    // ---------------- Stage 1: line buffers and window ----------------
    logic [DATA_W-1:0] lb0_q [IMG_W];
    logic [DATA_W-1:0] lb1_q [IMG_W];
    logic [DATA_W-1:0] win_q [3][3];
    logic [AW-1:0]     lb_idx;
    logic [DATA_W-1:0] col_top, col_mid;

    assign lb_idx  = x[AW-1:0];
    assign col_top = lb1_q[lb_idx];
    assign col_mid = lb0_q[lb_idx];

    // Data path carries no reset; only the tokens below decide what is emitted.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[lb_idx] <= col_mid;
            lb0_q[lb_idx] <= data_in;
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= col_top;
            win_q[1][2] <= col_mid;
            win_q[2][2] <= data_in;
        end
    end

    logic       s1_vld_q, s1_last_q;
    logic [1:0] s1_mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_mode_q <= 2'b00;
        end else begin
            s1_vld_q  <= accept && (x >= TWO) && (y >= TWO);
            s1_last_q <= accept && is_last;
            if (accept) s1_mode_q <= start ? mode : mode_q;
        end
    end

    // ---------------- Stage 2: kernel ----------------
    function automatic logic signed [GW-1:0] ext(input logic [DATA_W-1:0] p);
        return signed'({4'b0000, p});
    endfunction

    function automatic logic [DATA_W-1:0] sat(input logic [GW:0] v);
        return (v > SAT_MAX) ? {DATA_W{1'b1}} : v[DATA_W-1:0];
    endfunction

    logic signed [GW-1:0] gx, gy;
    logic [GW-1:0]        ax, ay;
    logic [GW:0]          mag;
    logic [DATA_W-1:0]    res_d;

    always_comb begin
        gx = (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2]))
           - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
        gy = (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][2]))
           - (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(win_q[0][2]));
        ax  = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
        ay  = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
        mag = {1'b0, ax} + {1'b0, ay};
        unique case (s1_mode_q)
            2'b00:   res_d = sat({1'b0, ax});
            2'b01:   res_d = sat({1'b0, ay});
            2'b10:   res_d = sat(mag);
            default: res_d = win_q[1][1];
        endcase
`ifdef CONV_THRESH_EN
        if (s1_mode_q != 2'b11) begin
            res_d = (res_d >= thresh_q) ? {DATA_W{1'b1}} : '0;
        end
`endif
    end

    logic [DATA_W-1:0] s2_res_q;
    logic              s2_vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_res_q  <= '0;
            s2_vld_q  <= 1'b0;
            s2_last_q <= 1'b0;
        end else begin
            s2_vld_q  <= s1_vld_q;
            s2_last_q <= s1_last_q;
            if (s1_vld_q) s2_res_q <= res_d;
        end
    end

    // ---------------- Output register ----------------
    logic [DATA_W-1:0] data_out_q;
    logic              valid_q, frame_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q   <= '0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            valid_q      <= s2_vld_q;
            frame_done_q <= s2_last_q;
            if (s2_vld_q) data_out_q <= s2_res_q;
        end
    end

    assign data_out   = data_out_q;
    assign valid      = valid_q;
    assign frame_done = frame_done_q;
    assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream: an 8x6 instance for mode, stall, sequence and reset cases, plus a 1280x3 instance for saturation.
module tb_conv3x3_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] d_in;
    logic        d_read;
    logic [10:0] d_x, d_y;
    logic [1:0]  d_mode;
    logic [11:0] d_out;
    logic        d_valid, d_fd, d_err;

    logic [11:0] w_in;
    logic        w_read;
    logic [10:0] w_x, w_y;
    logic [1:0]  w_mode;
    logic [11:0] w_out;
    logic        w_valid, w_fd, w_err;
`ifdef CONV_THRESH_EN
    logic [11:0] thresh;
`endif

    always #5 clk = ~clk;

    conv3x3_stream #(.DATA_W(12), .IMG_W(8), .IMG_H(6), .COORD_W(11)) u_dut (
        .clk(clk), .rst(rst), .data_in(d_in), .read(d_read), .x(d_x), .y(d_y),
`ifdef CONV_THRESH_EN
        .thresh(thresh),
`endif
        .mode(d_mode), .data_out(d_out), .valid(d_valid), .frame_done(d_fd), .seq_err(d_err)
    );

    conv3x3_stream #(.DATA_W(12), .IMG_W(1280), .IMG_H(3), .COORD_W(11)) u_wide (
        .clk(clk), .rst(rst), .data_in(w_in), .read(w_read), .x(w_x), .y(w_y),
`ifdef CONV_THRESH_EN
        .thresh(thresh),
`endif
        .mode(w_mode), .data_out(w_out), .valid(w_valid), .frame_done(w_fd), .seq_err(w_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int c22 = 0;
    int q_val[$];
    int q_cyc[$];
    int fd_count = 0;
    int fd_at = 0;
    int w_cnt = 0;
    int w_bad = 0;
    int w_fd_cnt = 0;
    logic [11:0] w_exp = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (d_valid) begin
            q_val.push_back(int'(d_out));
            q_cyc.push_back(cyc);
        end
        if (d_fd) begin
            fd_count <= fd_count + 1;
            fd_at    <= q_val.size();
        end
        if (w_valid) begin
            w_cnt <= w_cnt + 1;
            if (w_out !== w_exp) w_bad <= w_bad + 1;
        end
        if (w_fd) w_fd_cnt <= w_fd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Raw gradient/centre value after the optional threshold.
    function automatic logic [11:0] expect_px(input logic [1:0] m, input int raw);
        logic [11:0] v;
        v = 12'(raw);
`ifdef CONV_THRESH_EN
        if (m != 2'b11) v = (v >= thresh) ? 12'hFFF : 12'h000;
`endif
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic px(input int px_x, input int px_y, input logic rd);
        d_x    = 11'(px_x);
        d_y    = 11'(px_y);
        d_in   = 12'(px_y * 8 + px_x + 1);
        d_read = rd;
        tick();
    endtask

    task automatic clear_mon();
        q_val.delete();
        q_cyc.delete();
        fd_count = 0;
        fd_at    = 0;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (fd_count != 0) break;
            tick();
        end
        repeat (3) tick();
    endtask

    // mode_chg flips the mode input at pixel (3,3); the latched mode must not follow.
    task automatic run_frame(input logic [1:0] m, input bit toggle, input bit mode_chg);
        clear_mon();
        d_mode = m;
        for (int yy = 0; yy < 6; yy++) begin
            for (int xx = 0; xx < 8; xx++) begin
                if (mode_chg && xx == 3 && yy == 3) d_mode = ~m;
                px(xx, yy, 1'b1);
                if (xx == 2 && yy == 2) c22 = cyc;
                if (toggle) px(xx, yy, 1'b0);
            end
        end
        d_read = 1'b0;
        wait_done(40);
    endtask

    task automatic check_frame(input string tag, input logic [1:0] m, input bit lat);
        int raw;
        check({tag, "_count"}, q_val.size(), 24);
        check({tag, "_done_pulses"}, fd_count, 1);
        check({tag, "_done_with_last"}, fd_at, 24);
        for (int k = 0; k < q_val.size() && k < 24; k++) begin
            case (m)
                2'b00:   raw = 8;
                2'b01:   raw = 64;
                2'b10:   raw = 72;
                default: raw = (2 + k / 6 - 1) * 8 + (2 + k % 6);
            endcase
            check($sformatf("%s_val%0d", tag, k), q_val[k], expect_px(m, raw));
        end
        if (lat && q_cyc.size() > 0) check({tag, "_latency"}, q_cyc[0] - c22, 2);
    endtask

    initial begin
`ifdef CONV_THRESH_EN
        thresh = 12'd50;
`endif
        rst = 1'b1;
        d_in = '0; d_read = 1'b0; d_x = '0; d_y = '0; d_mode = 2'b00;
        w_in = '0; w_read = 1'b0; w_x = '0; w_y = '0; w_mode = 2'b00;
        repeat (3) tick();
        check("rst_data_out", d_out, 0);
        check("rst_valid", d_valid, 0);
        check("rst_frame_done", d_fd, 0);
        check("rst_seq_err", d_err, 0);
        rst = 1'b0;
        repeat (2) tick();

        // Non-origin reads in IDLE are ignored without error.
        clear_mon();
        px(3, 2, 1'b1);
        px(4, 2, 1'b1);
        d_read = 1'b0;
        repeat (5) tick();
        check("idle_ignore_err", d_err, 0);
        check("idle_ignore_valid", q_val.size(), 0);

        run_frame(2'b00, 1'b0, 1'b0);
        check_frame("m00", 2'b00, 1'b1);
        run_frame(2'b01, 1'b0, 1'b0);
        check_frame("m01", 2'b01, 1'b0);
        run_frame(2'b10, 1'b0, 1'b0);
        check_frame("m10", 2'b10, 1'b0);
        run_frame(2'b11, 1'b0, 1'b0);
        check_frame("m11", 2'b11, 1'b0);
        run_frame(2'b00, 1'b1, 1'b0);
        check_frame("stall", 2'b00, 1'b0);
        run_frame(2'b01, 1'b0, 1'b1);
        check_frame("mode_chg", 2'b01, 1'b0);

        // Coordinate skip (4,2) -> (6,2).
        clear_mon();
        d_mode = 2'b00;
        for (int yy = 0; yy < 6; yy++) begin
            for (int xx = 0; xx < 8; xx++) begin
                if (!(xx == 5 && yy == 2)) px(xx, yy, 1'b1);
            end
        end
        d_read = 1'b0;
        repeat (6) tick();
        check("skip_seq_err", d_err, 1);
        check("skip_count", q_val.size(), 3);
        check("skip_no_done", fd_count, 0);
        for (int k = 0; k < q_val.size() && k < 3; k++) begin
            check($sformatf("skip_val%0d", k), q_val[k], expect_px(2'b00, 8));
        end
        run_frame(2'b00, 1'b0, 1'b0);
        check_frame("after_skip", 2'b00, 1'b0);
        check("seq_err_sticky", d_err, 1);

        // Reset asserted together with pixel (5,3).
        clear_mon();
        d_mode = 2'b00;
        begin : rst_frame
            for (int yy = 0; yy < 6; yy++) begin
                for (int xx = 0; xx < 8; xx++) begin
                    if (xx == 5 && yy == 3) begin
                        rst = 1'b1;
                        px(xx, yy, 1'b1);
                        disable rst_frame;
                    end
                    px(xx, yy, 1'b1);
                end
            end
        end
        check("midrst_valid", d_valid, 0);
        check("midrst_data_out", d_out, 0);
        check("midrst_seq_err", d_err, 0);
        check("midrst_frame_done", d_fd, 0);
        rst = 1'b0;
        d_read = 1'b0;
        clear_mon();
        repeat (5) tick();
        check("midrst_drained", q_val.size(), 0);
        run_frame(2'b00, 1'b0, 1'b0);
        check_frame("after_rst", 2'b00, 1'b1);

        // Wide image: Gy = 10240 saturates to 4095.
        w_exp  = expect_px(2'b01, 4095);
        w_mode = 2'b01;
        for (int yy = 0; yy < 3; yy++) begin
            for (int xx = 0; xx < 1280; xx++) begin
                w_x = 11'(xx);
                w_y = 11'(yy);
                w_in = 12'(yy * 1280 + xx + 1);
                w_read = 1'b1;
                tick();
            end
        end
        w_read = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (w_fd_cnt != 0) break;
            tick();
        end
        repeat (3) tick();
        check("wide_count", w_cnt, 1278);
        check("wide_bad_values", w_bad, 0);
        check("wide_done", w_fd_cnt, 1);
        check("wide_seq_err", w_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
